// File: rtl/led_string_decoder.sv
// Receive-side decoder for the single-wire LED string protocol: measures high-pulse widths,
// rebuilds MSB-first pixel words and reports frame boundaries and sticky protocol errors.
module led_string_decoder #(
    parameter int BITS_PER_LED    = 24,
    parameter int MIN_HIGH_CYCLES = 3,
    parameter int THRESH_CYCLES   = 12,
    parameter int MAX_HIGH_CYCLES = 40,
    parameter int RESET_CYCLES    = 1000,
    parameter int MAX_PIXELS      = 236,
    parameter int INDEX_WIDTH     = 9
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sdi,
    input  logic                    err_clear,
    output logic [BITS_PER_LED-1:0] pixel_data,
    output logic                    pixel_valid,
    output logic [INDEX_WIDTH-1:0]  pixel_index,
    output logic                    frame_done,
    output logic [INDEX_WIDTH-1:0]  frame_pixels,
    output logic                    err_glitch,
    output logic                    err_stuck,
    output logic                    err_partial,
    output logic                    err_overflow
);

    localparam int BCW = $clog2(BITS_PER_LED + 1);
    localparam logic [15:0] RESET16  = 16'(RESET_CYCLES);
    localparam logic [15:0] MAXH16   = 16'(MAX_HIGH_CYCLES);
    localparam logic [15:0] MINH16   = 16'(MIN_HIGH_CYCLES);
    localparam logic [15:0] THRESH16 = 16'(THRESH_CYCLES);

    typedef enum logic [1:0] {S_RESYNC, S_LOW, S_HIGH} state_t;

    state_t                  state_q, state_d;
    logic                    sdi_meta_q, sdi_s_q, sdi_dly_q;
    logic [15:0]             low_cnt_q, low_cnt_d;
    logic [15:0]             high_cnt_q, high_cnt_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [INDEX_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d;
    logic [BITS_PER_LED-1:0] pixel_data_q, pixel_data_d;
    logic                    pixel_valid_q, pixel_valid_d;
    logic [INDEX_WIDTH-1:0]  pixel_index_q, pixel_index_d;
    logic                    frame_done_q, frame_done_d;
    logic [INDEX_WIDTH-1:0]  frame_pixels_q, frame_pixels_d;
    logic                    err_glitch_q, err_glitch_d;
    logic                    err_stuck_q, err_stuck_d;
    logic                    err_partial_q, err_partial_d;
    logic                    err_overflow_q, err_overflow_d;
    logic                    set_glitch, set_stuck, set_partial, set_overflow;
    logic                    bit_val;
    logic                    rise, fall;
    logic [15:0]             low_inc, high_inc;

    assign rise     = sdi_s_q & ~sdi_dly_q;
    assign fall     = ~sdi_s_q & sdi_dly_q;
    assign low_inc  = (low_cnt_q < RESET16) ? low_cnt_q + 16'd1 : low_cnt_q;
    assign high_inc = (high_cnt_q < MAXH16) ? high_cnt_q + 16'd1 : high_cnt_q;

    always_comb begin
        state_d        = state_q;
        low_cnt_d      = low_cnt_q;
        high_cnt_d     = high_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        shift_d        = shift_q;
        pixel_data_d   = pixel_data_q;
        pixel_valid_d  = 1'b0;
        pixel_index_d  = pixel_index_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        set_glitch     = 1'b0;
        set_stuck      = 1'b0;
        set_partial    = 1'b0;
        set_overflow   = 1'b0;
        bit_val        = 1'b0;

        case (state_q)
            S_RESYNC: begin
                if (sdi_s_q) begin
                    low_cnt_d = 16'd0;
                end else begin
                    low_cnt_d = low_inc;
                    // Leaving with the counter saturated suppresses a frame end for this gap.
                    if (low_inc == RESET16) state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d    = S_HIGH;
                    high_cnt_d = 16'd1;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_cnt_q == RESET16 - 16'd1 &&
                        (bit_cnt_q != '0 || pix_cnt_q != '0)) begin
                        frame_done_d   = 1'b1;
                        frame_pixels_d = pix_cnt_q;
                        set_partial    = (bit_cnt_q != '0);
                        bit_cnt_d      = '0;
                        pix_cnt_d      = '0;
                    end
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_d   = S_LOW;
                    low_cnt_d = 16'd1;
                    if (high_cnt_q < MINH16) begin
                        set_glitch = 1'b1;
                    end else begin
                        bit_val = (high_cnt_q >= THRESH16);
                        shift_d = {shift_q[BITS_PER_LED-2:0], bit_val};
                        if (bit_cnt_q == BCW'(BITS_PER_LED - 1)) begin
                            pixel_data_d  = shift_d;
                            pixel_valid_d = 1'b1;
                            pixel_index_d = pix_cnt_q;
                            bit_cnt_d     = '0;
                            if (pix_cnt_q == INDEX_WIDTH'(MAX_PIXELS)) begin
                                set_overflow = 1'b1;
                            end else begin
                                pix_cnt_d = pix_cnt_q + INDEX_WIDTH'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end else if (sdi_s_q) begin
                    high_cnt_d = high_inc;
                    if (high_inc >= MAXH16) begin
                        set_stuck = 1'b1;
                        state_d   = S_RESYNC;
                        low_cnt_d = 16'd0;
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_RESYNC;
        endcase

        // A new error in the same cycle as err_clear keeps its flag set.
        err_glitch_d   = (err_glitch_q   & ~err_clear) | set_glitch;
        err_stuck_d    = (err_stuck_q    & ~err_clear) | set_stuck;
        err_partial_d  = (err_partial_q  & ~err_clear) | set_partial;
        err_overflow_d = (err_overflow_q & ~err_clear) | set_overflow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdi_meta_q     <= 1'b0;
            sdi_s_q        <= 1'b0;
            sdi_dly_q      <= 1'b0;
            state_q        <= S_RESYNC;
            low_cnt_q      <= 16'd0;
            high_cnt_q     <= 16'd0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            shift_q        <= '0;
            pixel_data_q   <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_index_q  <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            err_glitch_q   <= 1'b0;
            err_stuck_q    <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            sdi_meta_q     <= sdi;
            sdi_s_q        <= sdi_meta_q;
            sdi_dly_q      <= sdi_s_q;
            state_q        <= state_d;
            low_cnt_q      <= low_cnt_d;
            high_cnt_q     <= high_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            shift_q        <= shift_d;
            pixel_data_q   <= pixel_data_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_index_q  <= pixel_index_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            err_glitch_q   <= err_glitch_d;
            err_stuck_q    <= err_stuck_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_index  = pixel_index_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign err_glitch   = err_glitch_q;
    assign err_stuck    = err_stuck_q;
    assign err_partial  = err_partial_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_led_string_decoder.sv
// Bench for led_string_decoder: run-length reference model compared every cycle, plus
// literal expectations for the directed frames.
`timescale 1ns/1ps
module tb_led_string_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sdi = 1'b0;
    logic        err_clear = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [8:0]  pixel_index;
    logic        frame_done;
    logic [8:0]  frame_pixels;
    logic        err_glitch, err_stuck, err_partial, err_overflow;

    int checks = 0;
    int failures = 0;

    led_string_decoder dut (
        .clk(clk), .reset_n(reset_n), .sdi(sdi), .err_clear(err_clear),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
        .frame_done(frame_done), .frame_pixels(frame_pixels),
        .err_glitch(err_glitch), .err_stuck(err_stuck),
        .err_partial(err_partial), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on runs of the sampled line, delayed by the two synchronizer stages.
    logic        m_d0, m_d1;
    logic        m_synced, m_in_pulse;
    int          m_low_run, m_high_run, m_bits, m_pix;
    logic [23:0] m_word;
    logic        e_pv, e_fd, e_eg, e_es, e_ep, e_eo;
    logic [23:0] e_pd;
    logic [8:0]  e_pi, e_fp;

    task automatic model_clear();
        m_d0 = 0; m_d1 = 0; m_synced = 0; m_in_pulse = 0;
        m_low_run = 0; m_high_run = 0; m_bits = 0; m_pix = 0; m_word = '0;
        e_pv = 0; e_fd = 0; e_eg = 0; e_es = 0; e_ep = 0; e_eo = 0;
        e_pd = '0; e_pi = '0; e_fp = '0;
    endtask

    task automatic model_step();
        logic cur;
        cur  = m_d1;
        m_d1 = m_d0;
        m_d0 = sdi;
        e_pv = 0;
        e_fd = 0;
        if (err_clear) begin
            e_eg = 0; e_es = 0; e_ep = 0; e_eo = 0;
        end
        if (!m_synced) begin
            if (cur) m_low_run = 0;
            else begin
                m_low_run++;
                if (m_low_run == 1000) m_synced = 1;
            end
        end else if (cur) begin
            if (!m_in_pulse) begin
                m_in_pulse = 1;
                m_high_run = 1;
            end else begin
                m_high_run++;
                if (m_high_run >= 40) begin
                    e_es = 1; m_synced = 0; m_in_pulse = 0;
                    m_low_run = 0; m_bits = 0; m_pix = 0;
                end
            end
        end else if (m_in_pulse) begin
            m_in_pulse = 0;
            m_low_run = 1;
            if (m_high_run < 3) e_eg = 1;
            else begin
                m_word = {m_word[22:0], (m_high_run >= 12)};
                m_bits++;
                if (m_bits == 24) begin
                    e_pv = 1; e_pd = m_word; e_pi = 9'(m_pix); m_bits = 0;
                    if (m_pix == 236) e_eo = 1;
                    else m_pix++;
                end
            end
        end else if (m_low_run < 1000) begin
            m_low_run++;
            if (m_low_run == 1000 && (m_bits != 0 || m_pix != 0)) begin
                e_fd = 1; e_fp = 9'(m_pix);
                if (m_bits != 0) e_ep = 1;
                m_bits = 0; m_pix = 0;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    logic [32:0] cap_pix[$];
    int          cap_fp[$];

    initial begin
        logic [63:0] act, exp;
        forever begin
            @(negedge clk);
            act = {16'd0, pixel_valid, pixel_index, pixel_data, frame_done, frame_pixels,
                   err_glitch, err_stuck, err_partial, err_overflow};
            exp = {16'd0, e_pv, e_pi, e_pd, e_fd, e_fp, e_eg, e_es, e_ep, e_eo};
            chk("model_outputs", act, exp);
            if (pixel_valid) cap_pix.push_back({pixel_index, pixel_data});
            if (frame_done) cap_fp.push_back(int'(frame_pixels));
        end
    end

    function automatic logic [32:0] pix_at(int i);
        if (i < 0 || i >= cap_pix.size()) return '1;
        return cap_pix[i];
    endfunction

    function automatic int fp_at(int i);
        if (i < 0 || i >= cap_fp.size()) return -1;
        return cap_fp[i];
    endfunction

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(int h, int l);
        sdi = 1'b1; cyc(h);
        sdi = 1'b0; cyc(l);
    endtask

    task automatic send_range(logic [23:0] w, int lo, int hi, int h1, int h0, int l1, int l0);
        for (int i = lo; i < hi; i++) begin
            if (w[23-i]) pulse(h1, l1);
            else pulse(h0, l0);
        end
    endtask

    task automatic send_word(logic [23:0] w);
        send_range(w, 0, 24, 16, 8, 9, 17);
    endtask

    task automatic clear_errs();
        err_clear = 1'b1; cyc(1); err_clear = 1'b0;
    endtask

    initial begin
        int np, nf, npix, h, mode;
        logic [23:0] w;
        logic [32:0] pexp [3];

        cyc(5);
        reset_n = 1'b1;

        // Basic pixel and frame end
        cyc(1000);
        np = cap_pix.size(); nf = cap_fp.size();
        send_word(24'hA53C0F);
        cyc(1000);
        chk("s1_pixel", 64'(pix_at(np)), 64'({9'd0, 24'hA53C0F}));
        chk("s1_frame_pixels", 64'(fp_at(nf)), 64'(1));
        chk("s1_no_errors", 64'({err_glitch, err_stuck, err_partial, err_overflow}), 64'(0));

        // Three pixels with threshold-boundary pulses (12 high -> 1, 11 high -> 0)
        np = cap_pix.size(); nf = cap_fp.size();
        send_range(24'h000000, 0, 24, 12, 11, 13, 13);
        send_range(24'hFFFFFF, 0, 24, 12, 11, 13, 13);
        send_range(24'h123456, 0, 24, 12, 11, 13, 13);
        cyc(1000);
        pexp[0] = {9'd0, 24'h000000};
        pexp[1] = {9'd1, 24'hFFFFFF};
        pexp[2] = {9'd2, 24'h123456};
        for (int i = 0; i < 3; i++) chk("s2_pixel", 64'(pix_at(np + i)), 64'(pexp[i]));
        chk("s2_frame_pixels", 64'(fp_at(nf)), 64'(3));

        // Glitch between bits
        np = cap_pix.size();
        send_range(24'hA53C0F, 0, 7, 16, 8, 9, 17);
        pulse(2, 10);
        send_range(24'hA53C0F, 7, 24, 16, 8, 9, 17);
        cyc(1000);
        chk("s3_pixel", 64'(pix_at(np)), 64'({9'd0, 24'hA53C0F}));
        chk("s3_glitch_set", 64'(err_glitch), 64'(1));
        clear_errs();
        cyc(1);
        chk("s3_glitch_cleared", 64'(err_glitch), 64'(0));

        // Stuck line mid-frame, bits ignored until a full gap
        np = cap_pix.size(); nf = cap_fp.size();
        send_range(24'hA53C0F, 0, 5, 16, 8, 9, 17);
        sdi = 1'b1; cyc(40);
        sdi = 1'b0; cyc(20);
        send_range(24'hFFFFFF, 0, 3, 16, 8, 9, 17);
        cyc(1000);
        chk("s4_stuck_set", 64'(err_stuck), 64'(1));
        chk("s4_no_frame_done", 64'(cap_fp.size() - nf), 64'(0));
        chk("s4_no_pixel", 64'(cap_pix.size() - np), 64'(0));
        clear_errs();

        // Partial word
        nf = cap_fp.size();
        send_range(24'hA53C0F, 0, 10, 16, 8, 9, 17);
        cyc(1000);
        chk("s5_partial_frame_pixels", 64'(fp_at(nf)), 64'(0));
        chk("s5_partial_flag", 64'(err_partial), 64'(1));
        clear_errs();

        // Overflow: 237 pixels in one frame
        np = cap_pix.size(); nf = cap_fp.size();
        for (int p = 0; p < 237; p++) send_range(24'h000000, 0, 24, 12, 3, 3, 3);
        cyc(1000);
        chk("s5_overflow_count", 64'(cap_pix.size() - np), 64'(237));
        chk("s5_overflow_last", 64'(pix_at(np + 236)), 64'({9'd236, 24'h000000}));
        chk("s5_overflow_flag", 64'(err_overflow), 64'(1));
        chk("s5_overflow_frame_pixels", 64'(fp_at(nf)), 64'(236));

        // Reset mid-pixel
        send_range(24'hA53C0F, 0, 12, 16, 8, 9, 17);
        #2 reset_n = 1'b0;
        #1 chk("s6_async_reset_outputs",
               64'({pixel_valid, pixel_index, pixel_data, frame_done, frame_pixels,
                    err_glitch, err_stuck, err_partial, err_overflow}), 64'(0));
        sdi = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        np = cap_pix.size(); nf = cap_fp.size();
        send_word(24'hA53C0F);
        cyc(1000);
        chk("s6_no_decode_before_gap", 64'(cap_pix.size() - np), 64'(0));
        chk("s6_no_frame_before_gap", 64'(cap_fp.size() - nf), 64'(0));
        send_word(24'hA53C0F);
        cyc(1000);
        chk("s6_decode_after_gap", 64'(pix_at(np)), 64'({9'd0, 24'hA53C0F}));
        chk("s6_frame_after_gap", 64'(fp_at(nf)), 64'(1));

        // Randomized frames: widths, glitches, partial words, stuck lines, error clears
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 1) clear_errs();
            npix = int'($urandom_range(1, 3));
            for (int p = 0; p < npix; p++) begin
                w = 24'($urandom);
                for (int i = 0; i < 24; i++) begin
                    if ($urandom_range(0, 39) == 0)
                        pulse(int'($urandom_range(1, 2)), int'($urandom_range(3, 10)));
                    h = w[23-i] ? int'($urandom_range(12, 39)) : int'($urandom_range(3, 11));
                    pulse(h, int'($urandom_range(3, 20)));
                end
            end
            mode = int'($urandom_range(0, 5));
            if (mode == 0) begin
                send_range(24'($urandom), 0, int'($urandom_range(1, 23)), 16, 8, 9, 17);
            end else if (mode == 1) begin
                sdi = 1'b1; cyc(int'($urandom_range(40, 45)));
                sdi = 1'b0;
            end
            cyc(int'($urandom_range(1000, 1060)));
        end

        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_string_decoder.md
# led_string_decoder

Receive-side decoder for the single-wire LED string protocol driven on `led_sdi`. It samples one string output at `clk` (20 MHz), measures high-pulse widths, and rebuilds 24-bit pixel words MSB-first. It detects the inter-frame latch gap and reports pixel words, frame boundaries and protocol errors. It is instantiated per string in loopback/self-test builds and in benches to check `parallel_strings` output against the written FIFO contents.

## Interface

Parameters:
- `BITS_PER_LED`, 24: bits per pixel word.
- `MIN_HIGH_CYCLES`, 3: high pulses shorter than this are glitches.
- `THRESH_CYCLES`, 12: high pulse of at least this many cycles decodes as 1; shorter decodes as 0.
- `MAX_HIGH_CYCLES`, 40: high pulse reaching this many cycles is a stuck line.
- `RESET_CYCLES`, 1000: low time that ends a frame (50 µs at 20 MHz).
- `MAX_PIXELS`, 236: pixels allowed per frame.
- `INDEX_WIDTH`, 9: width of the pixel index and count.

Ports:
- `clk`, in, 1: decoder clock (clk_20 domain).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `sdi`, in, 1: string serial line; asynchronous to `clk`; synchronized internally.
- `err_clear`, in, 1: one-cycle pulse that clears the sticky error flags.
- `pixel_data`, out, BITS_PER_LED: last complete pixel word.
- `pixel_valid`, out, 1: one-cycle strobe; `pixel_data` and `pixel_index` are valid.
- `pixel_index`, out, INDEX_WIDTH: position of the strobed pixel in the frame (0-based).
- `frame_done`, out, 1: one-cycle strobe at the end of the latch gap.
- `frame_pixels`, out, INDEX_WIDTH: complete pixels in the frame just ended; held until the next `frame_done`.
- `err_glitch`, `err_stuck`, `err_partial`, `err_overflow`, out, 1 each: sticky error flags.

## Operation

Input conditioning:
- `sdi` passes through two flops to give `sdi_s`, then one more to give `sdi_q`.
- Rise: `sdi_s & ~sdi_q`. Fall: `~sdi_s & sdi_q`.

States:
- RESYNC: entered at reset and after a stuck-line error. Waits for `sdi_s` low for RESET_CYCLES consecutive cycles, then goes to LOW. No `frame_done` is issued on this exit.
- LOW: the low counter increments each cycle. A rise moves to HIGH and sets the high counter to 1.
  - When the low counter reaches RESET_CYCLES and anything was received since the last frame end (bit count or pixel count nonzero), the frame-end action runs:
    - `frame_done` pulses and `frame_pixels` is loaded with the pixel count.
    - If bit count is nonzero, `err_partial` sets.
    - Bit count and pixel count clear.
  - The low counter saturates at RESET_CYCLES, so the frame-end action runs once per gap.
- HIGH: the high counter increments each cycle that `sdi_s` is high.
  - If the counter reaches MAX_HIGH_CYCLES: `err_stuck` sets, bit and pixel counts clear, state goes to RESYNC.
  - On a fall with count below MIN_HIGH_CYCLES: `err_glitch` sets, the bit is discarded, state goes to LOW.
  - On any other fall: decoded bit = (count >= THRESH_CYCLES). It shifts into the LSB of the shift register (MSB-first word), bit count increments, and state goes to LOW with the low counter at 1.
- Word complete: when bit count reaches BITS_PER_LED:
  - `pixel_data` is loaded with the assembled word, `pixel_valid` pulses and `pixel_index` is loaded with the pixel count.
  - Pixel count increments and bit count clears.
  - If the pixel count was already MAX_PIXELS, `err_overflow` sets, the word is still strobed, and the count saturates at MAX_PIXELS.

Errors:
- All error flags are sticky and cleared by `err_clear`.
- If `err_clear` and a new error occur in the same cycle, the new error wins (flag stays 1).

Widths: both counters are 16-bit and saturating. Bit count is ceil(log2(BITS_PER_LED+1)) bits.

## Timing

- Reset values: all outputs 0, state RESYNC, shift register 0.
- A pin transition first sampled at edge k appears on `sdi_s` at edge k+1.
- The output registers update at edge k+2. `pixel_valid`, `frame_done` and error flags rise at edge k+2 after the edge that first samples the relevant pin level.
- The high count equals the number of edges on which the first synchronizer flop sampled 1.
- A pulse of exactly THRESH_CYCLES decodes as 1. A pulse of exactly MIN_HIGH_CYCLES is valid.
- `frame_done` asserts on the cycle the low counter equals RESET_CYCLES, with the same +2 pipeline.
- `reset_n` deasserted mid-pixel:
  - Immediate clear of all state and outputs.
  - The partial word is lost, with no error flag.
  - The decoder must see a full latch gap before it decodes again.

## Test plan

- After reset, hold low 1000 cycles, then send 24 bits encoding 0xA53C0F (0 = 8 high/17 low, 1 = 16 high/9 low) -> one `pixel_valid`, `pixel_data`=0xA53C0F, `pixel_index`=0. Low 1000 cycles -> `frame_done`, `frame_pixels`=1, no errors.
- Three pixels 0x000000, 0xFFFFFF, 0x123456 then 1000 low -> indices 0,1,2 with matching data, `frame_pixels`=3. Boundary pulses of 12 and 11 high cycles decode as 1 and 0.
- A 2-cycle high pulse inserted between bits -> `err_glitch`=1, word still 0xA53C0F on the next 24 valid bits. `err_clear` -> flag 0.
- Line held high 40 cycles mid-frame -> `err_stuck`=1. Bits are ignored until 1000 low cycles pass; no `frame_done` for the aborted frame.
- 10 bits then 1000 low -> `frame_done`, `frame_pixels`=0, `err_partial`=1. 237 pixels in one frame -> `err_overflow`=1, `frame_pixels`=236.
- Pull `reset_n` low after 12 bits -> all outputs 0 asynchronously. Release, resend the full pixel -> decoded only after the latch gap.
